// File: rtl/neuron_o_backprop.sv
// Output-layer backprop step: delta = (y - target)(1 - y^2), then SGD update of w_1, w_2, b.
// One shared Q8.24 multiplier is sequenced by a nine-state FSM; results land together at DONE.
module neuron_o_backprop #(
  parameter int WIDTH = 32,
  parameter int FBITS = 24
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] target,
  input  logic signed [WIDTH-1:0] a_1,
  input  logic signed [WIDTH-1:0] a_2,
  input  logic signed [WIDTH-1:0] w_1,
  input  logic signed [WIDTH-1:0] w_2,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] lr,
  output logic signed [WIDTH-1:0] delta,
  output logic signed [WIDTH-1:0] w_1_new,
  output logic signed [WIDTH-1:0] w_2_new,
  output logic signed [WIDTH-1:0] b_new,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              dbg_state_o
);

  localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-FBITS-1){1'b0}}, 1'b1, {FBITS{1'b0}}};

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    ERR  = 4'd1,
    DER  = 4'd2,
    DEL  = 4'd3,
    SCL  = 4'd4,
    G1   = 4'd5,
    G2   = 4'd6,
    GB   = 4'd7,
    DONE = 4'd8
  } state_t;

  state_t state_q;

  logic signed [WIDTH-1:0] y_q, target_q, a1_q, a2_q, w1_q, w2_q, b_q, lr_q;
  logic signed [WIDTH-1:0] e_q, p_q, d_q, dl_q, s_q, w1n_q, w2n_q;
  logic signed [WIDTH-1:0] delta_q, w1_new_q, w2_new_q, b_new_q;
  logic                    busy_q, done_q;

  logic signed [WIDTH-1:0]   mul_a, mul_b, mul_res;
  logic signed [2*WIDTH-1:0] mul_full;
  logic signed [WIDTH-1:0]   bn_d;

  // Operand select for the shared multiplier; states without a product feed zeros.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      ERR:     begin mul_a = y_q;  mul_b = y_q;  end
      DEL:     begin mul_a = e_q;  mul_b = d_q;  end
      SCL:     begin mul_a = lr_q; mul_b = dl_q; end
      G1:      begin mul_a = s_q;  mul_b = a1_q; end
      G2:      begin mul_a = s_q;  mul_b = a2_q; end
      default: begin mul_a = '0;   mul_b = '0;   end
    endcase
  end

  // Full-width signed product, arithmetic shift floors toward -inf, then wrap to WIDTH.
  assign mul_full = mul_a * mul_b;
  assign mul_res  = WIDTH'(mul_full >>> FBITS);
  assign bn_d     = b_q - s_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      y_q      <= '0; target_q <= '0; a1_q <= '0; a2_q <= '0;
      w1_q     <= '0; w2_q     <= '0; b_q  <= '0; lr_q <= '0;
      e_q      <= '0; p_q      <= '0; d_q  <= '0; dl_q <= '0;
      s_q      <= '0; w1n_q    <= '0; w2n_q <= '0;
      delta_q  <= '0; w1_new_q <= '0; w2_new_q <= '0; b_new_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            y_q <= y; target_q <= target; a1_q <= a_1; a2_q <= a_2;
            w1_q <= w_1; w2_q <= w_2; b_q <= b; lr_q <= lr;
            busy_q  <= 1'b1;
            state_q <= ERR;
          end
        end
        ERR: begin
          e_q     <= y_q - target_q;
          p_q     <= mul_res;
          state_q <= DER;
        end
        DER: begin
          d_q     <= ONE - p_q;
          state_q <= DEL;
        end
        DEL: begin
          dl_q    <= mul_res;
          state_q <= SCL;
        end
        SCL: begin
          s_q     <= mul_res;
          state_q <= G1;
        end
        G1: begin
          w1n_q   <= w1_q - mul_res;
          state_q <= G2;
        end
        G2: begin
          w2n_q   <= w2_q - mul_res;
          state_q <= GB;
        end
        GB: begin
          // Publish on entry to DONE so outputs and the done pulse appear together.
          delta_q  <= dl_q;
          w1_new_q <= w1n_q;
          w2_new_q <= w2n_q;
          b_new_q  <= bn_d;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign delta       = delta_q;
  assign w_1_new     = w1_new_q;
  assign w_2_new     = w2_new_q;
  assign b_new       = b_new_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/neuron_o_backprop.md
# neuron_o_backprop

Training-direction counterpart of the output neuron. From the forward output `y`, a `target`, the cached inputs `a_1`/`a_2` and the current `w_1`, `w_2`, `b`, it computes the output-layer error term delta = (y − target)·(1 − y²), where (1 − y²) is the tanh derivative. It then produces updated parameters w_i − lr·delta·a_i and b − lr·delta. A single shared Q8.24 multiplier is time-multiplexed by a state machine; the block sits between the forward datapath and the parameter registers of the output layer.

## Interface
- `WIDTH`, 32, data width of every signed fixed-point port
- `FBITS`, 24, fractional bits (Q8.24); ONE = 1 << FBITS = 0x01000000
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state on the edge it is sampled high
- `enable`  in  1  when low, FSM and all registers hold (global stall)
- `start`  in  1  request; sampled only in IDLE with `enable` high
- `y`, `target`, `a_1`, `a_2`, `w_1`, `w_2`, `b`, `lr`  in  WIDTH each  signed Q8.24 operands; captured on the edge that accepts `start`
- `delta`  out  WIDTH  signed Q8.24 error term of last completed operation
- `w_1_new`, `w_2_new`, `b_new`  out  WIDTH each  signed Q8.24 updated parameters
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when results become valid

## Operation
- Operand registers capture all eight inputs on accept; inputs may change afterwards.
- Multiplier: full 2·WIDTH signed product, arithmetic shift right by FBITS (floor toward −∞), low WIDTH bits kept. There is no saturation.
- Add/subtract: WIDTH-bit two's complement with wrap-around and no saturation.
- States and actions (each state lasts one enabled cycle):
  - IDLE: `busy`=0. On `start`&`enable`, capture operands and go to ERR; otherwise stay.
  - ERR: e ← y − target; p ← y·y → DER
  - DER: d ← ONE − p → DEL
  - DEL: dl ← e·d → SCL
  - SCL: s ← lr·dl → G1
  - G1: w1n ← w_1 − s·a_1 → G2
  - G2: w2n ← w_2 − s·a_2 → GB
  - GB: bn ← b − s → DONE
  - DONE: copy dl/w1n/w2n/bn to the outputs, `done`=1 → IDLE
- Outputs hold their last values until the next DONE.
- While busy, `start` is ignored and not queued.

## Timing
- Reset values: `delta`, `w_1_new`, `w_2_new`, `b_new` = 0; `busy` = 0; `done` = 0; state = IDLE; internal registers = 0.
- Latency:
  - Accepting edge = edge 0.
  - `busy` is high from after edge 0 until after edge 8.
  - Outputs update and `done` rises after edge 7 and stay high for exactly one cycle.
- Throughput: one operation per 9 cycles with `start` held high (DONE → IDLE → accept).
- `enable` low: no state, register or output change. `done` stays high if already in DONE, so the pulse stretches until the next enabled edge. Latency grows by the number of stalled cycles.
- Reset has priority over `enable` and `start`. Reset mid-operation aborts to IDLE with all outputs zeroed, and no `done` is issued.
- `start` coincident with `reset`: ignored.

## Test plan
- Nominal: y=0x00800000, target=0x01000000, lr=0x00800000, a_1=0x01000000, w_1=0x00400000, a_2=0xFE000000, w_2=0, b=0x00200000, start for 1 cycle -> `done` after 8 edges. Required outputs: delta=0xFFA00000, w_1_new=0x00700000, w_2_new=0xFFA00000, b_new=0x00500000.
- Zero error: y=target=0x00C00000, other operands arbitrary -> delta=0, each *_new equals its input parameter.
- Floor rounding: from nominal, set a_1=0x00000001 and w_1=0 -> w_1_new=0x00000001 (s·a_1 floors to −1 LSB).
- Stall: nominal stimulus, `enable` low for 3 cycles while in DEL -> same results, `done` 3 cycles later, all outputs unchanged during the stall.
- Reset mid-op: assert `reset` in G1 for one cycle -> next cycle all outputs 0, `busy`=0, no `done`. A fresh start then reproduces the nominal results.
- Back-to-back/ignored start: `start` held high across two ops, with the second op using target=y -> two `done` pulses 9 cycles apart. The second delta=0. Toggling `start` while busy has no effect.
